// File: rtl/flash_addr_seq_pkg.sv
// Shared types and key codes for the flash read-address sequencer.
// The state enum, key-code constants and the key-to-command decode live here.
package flash_addr_seq_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, STEP} seq_state_t;

    localparam logic [7:0] KEY_E = 8'h45;
    localparam logic [7:0] KEY_D = 8'h44;
    localparam logic [7:0] KEY_R = 8'h52;
    localparam logic [7:0] KEY_F = 8'h46;
    localparam logic [7:0] KEY_B = 8'h42;

    typedef enum logic [2:0] {
        CMD_NONE, CMD_PLAY, CMD_PAUSE, CMD_FWD, CMD_BWD, CMD_RESTART
    } kbd_cmd_t;

    function automatic kbd_cmd_t decode_key(input logic [7:0] code);
        case (code)
            KEY_E:   return CMD_PLAY;
            KEY_D:   return CMD_PAUSE;
            KEY_F:   return CMD_FWD;
            KEY_B:   return CMD_BWD;
            KEY_R:   return CMD_RESTART;
            default: return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/kbd_cmd_decode.sv
// Registered keyboard command decoder: turns a valid ASCII key into one-cycle
// play / pause / fwd / bwd / restart strobes; unknown codes produce nothing.
module kbd_cmd_decode
    import flash_addr_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] kbd_code,
    input  logic       kbd_valid,
    output logic       play,
    output logic       pause,
    output logic       fwd,
    output logic       bwd,
    output logic       restart
);

    kbd_cmd_t cmd;

    always_comb begin
        cmd = CMD_NONE;
        if (kbd_valid) cmd = decode_key(kbd_code);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            play    <= 1'b0;
            pause   <= 1'b0;
            fwd     <= 1'b0;
            bwd     <= 1'b0;
            restart <= 1'b0;
        end else begin
            play    <= (cmd == CMD_PLAY);
            pause   <= (cmd == CMD_PAUSE);
            fwd     <= (cmd == CMD_FWD);
            bwd     <= (cmd == CMD_BWD);
            restart <= (cmd == CMD_RESTART);
        end
    end

endmodule

// File: rtl/flash_addr_sequencer.sv
// Flash read-address sequencer: one flash read per sample tick, stepping the address
// by STEP inside [START_ADDR, END_ADDR]. Define FLASH_ADDR_SEQ_LOOP_EN to wrap at edges instead of clamping.
module flash_addr_sequencer #(
    parameter int unsigned       ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = 'h7FFFF,
    parameter logic [ADDR_W-1:0] STEP       = 'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        kbd_code,
    input  logic              kbd_valid,
    input  logic              sample_tick,
    input  logic              flash_finish,
    output logic              flash_start,
    output logic [ADDR_W-1:0] flash_addr,
    output logic              playing,
    output logic              dir_bwd,
    output logic              wrap,
    output logic              overrun
);

    // Explicit imports: the STEP parameter shadows the STEP state literal.
    import flash_addr_seq_pkg::seq_state_t;
    import flash_addr_seq_pkg::IDLE;
    import flash_addr_seq_pkg::REQ;
    import flash_addr_seq_pkg::WAIT;

    seq_state_t        state, state_nx;
    logic              play_s, pause_s, fwd_s, bwd_s, restart_s;
    logic              restart_pending;
    logic [ADDR_W-1:0] addr_nx;
    logic              wrap_nx, clamp;
    logic [ADDR_W:0]   fwd_sum;
    logic              fwd_hit, bwd_hit, finish_ok, restart_apply;

    kbd_cmd_decode u_kbd (
        .clk       (clk),
        .rst_n     (rst_n),
        .kbd_code  (kbd_code),
        .kbd_valid (kbd_valid),
        .play      (play_s),
        .pause     (pause_s),
        .fwd       (fwd_s),
        .bwd       (bwd_s),
        .restart   (restart_s)
    );

    // One extra bit so a step past the top of the address space still compares correctly.
    assign fwd_sum       = {1'b0, flash_addr} + {1'b0, STEP};
    assign fwd_hit       = fwd_sum > {1'b0, END_ADDR};
    assign bwd_hit       = {1'b0, flash_addr} < ({1'b0, START_ADDR} + {1'b0, STEP});
    assign finish_ok     = (state == WAIT) && flash_finish;
    assign restart_apply = restart_pending && (finish_ok || state == IDLE);
    assign flash_start   = (state == REQ);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sample_tick && playing) state_nx = REQ;
            REQ:     state_nx = WAIT;
            WAIT:    if (flash_finish) state_nx = flash_addr_seq_pkg::STEP;
            default: state_nx = IDLE;
        endcase
    end

    // The address is registered on the finish edge so it is visible the cycle after finish.
    always_comb begin
        addr_nx = flash_addr;
        wrap_nx = 1'b0;
        clamp   = 1'b0;
        if (restart_apply) begin
            addr_nx = dir_bwd ? END_ADDR : START_ADDR;
        end else if (finish_ok && playing) begin
            if (dir_bwd ? bwd_hit : fwd_hit) begin
                wrap_nx = 1'b1;
`ifdef FLASH_ADDR_SEQ_LOOP_EN
                addr_nx = dir_bwd ? END_ADDR : START_ADDR;
`else
                addr_nx = dir_bwd ? START_ADDR : END_ADDR;
                clamp   = 1'b1;
`endif
            end else begin
                addr_nx = dir_bwd ? (flash_addr - STEP) : fwd_sum[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            flash_addr      <= START_ADDR;
            playing         <= 1'b0;
            dir_bwd         <= 1'b0;
            wrap            <= 1'b0;
            overrun         <= 1'b0;
            restart_pending <= 1'b0;
        end else begin
            state      <= state_nx;
            flash_addr <= addr_nx;
            wrap       <= wrap_nx;

            if (restart_s)          restart_pending <= 1'b1;
            else if (restart_apply) restart_pending <= 1'b0;

            if (play_s || fwd_s || bwd_s || restart_s) playing <= 1'b1;
            else if (pause_s || clamp)                 playing <= 1'b0;

            if (fwd_s)      dir_bwd <= 1'b0;
            else if (bwd_s) dir_bwd <= 1'b1;

            if (sample_tick && state != IDLE) overrun <= 1'b1;
            else if (restart_s)               overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flash_addr_sequencer.sv
// Randomized bench for flash_addr_sequencer against a transaction-level reference model.
// Honours FLASH_ADDR_SEQ_LOOP_EN to pick the expected boundary behaviour.
module tb_flash_addr_sequencer;

    localparam int AW = 5;
    localparam int SA = 4;
    localparam int EA = 31;
    localparam int ST = 3;

    localparam logic [7:0] K_E = 8'h45;
    localparam logic [7:0] K_D = 8'h44;
    localparam logic [7:0] K_R = 8'h52;
    localparam logic [7:0] K_F = 8'h46;
    localparam logic [7:0] K_B = 8'h42;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    kbd_code = 8'h00;
    logic          kbd_valid = 1'b0;
    logic          sample_tick = 1'b0;
    logic          flash_finish = 1'b0;
    logic          flash_start;
    logic [AW-1:0] flash_addr;
    logic          playing, dir_bwd, wrap, overrun;

    int n_chk = 0;
    int n_fail = 0;

    int m_addr;
    bit m_play, m_bwd, m_pend, m_ovr, e_wrap;

    always #5 clk = ~clk;

    flash_addr_sequencer #(
        .ADDR_W     (AW),
        .START_ADDR (AW'(SA)),
        .END_ADDR   (AW'(EA)),
        .STEP       (AW'(ST))
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .kbd_code     (kbd_code),
        .kbd_valid    (kbd_valid),
        .sample_tick  (sample_tick),
        .flash_finish (flash_finish),
        .flash_start  (flash_start),
        .flash_addr   (flash_addr),
        .playing      (playing),
        .dir_bwd      (dir_bwd),
        .wrap         (wrap),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_addr = SA; m_play = 0; m_bwd = 0; m_pend = 0; m_ovr = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_addr"}, flash_addr, m_addr);
        chk({tag, "_play"}, playing, m_play);
        chk({tag, "_dir"}, dir_bwd, m_bwd);
        chk({tag, "_ovr"}, overrun, m_ovr);
    endtask

    task automatic apply_key(input logic [7:0] code);
        case (code)
            K_E: m_play = 1;
            K_D: m_play = 0;
            K_F: begin m_bwd = 0; m_play = 1; end
            K_B: begin m_bwd = 1; m_play = 1; end
            K_R: begin m_pend = 1; m_play = 1; m_ovr = 0; end
            default: ;
        endcase
    endtask

    // Expected result of one completed read, straight from the window/stride rules.
    task automatic ref_step();
        e_wrap = 0;
        if (m_pend) begin
            m_addr = m_bwd ? EA : SA;
            m_pend = 0;
        end else if (m_play) begin
            if ((!m_bwd && m_addr + ST > EA) || (m_bwd && m_addr < SA + ST)) begin
                e_wrap = 1;
`ifdef FLASH_ADDR_SEQ_LOOP_EN
                m_addr = m_bwd ? EA : SA;
`else
                m_addr = m_bwd ? SA : EA;
                m_play = 0;
`endif
            end else begin
                m_addr = m_bwd ? m_addr - ST : m_addr + ST;
            end
        end
    endtask

    function automatic logic [7:0] pick_key();
        logic [7:0] keys [5];
        int unsigned k;
        keys = '{K_E, K_D, K_F, K_B, K_R};
        k = $urandom_range(0, 6);
        if (k > 4) return 8'(8'h60 + $urandom_range(0, 31));
        return keys[k];
    endfunction

    task automatic press(input logic [7:0] code);
        kbd_code = code; kbd_valid = 1; cyc(); kbd_valid = 0;
        repeat (3) cyc();
        apply_key(code);
        if (m_pend) begin
            m_addr = m_bwd ? EA : SA;
            m_pend = 0;
        end
        chk("key_wrap", wrap, 0);
        check_state("key");
    endtask

    task automatic do_read(input int lat, input bit tick_mid, input bit key_mid,
                           input logic [7:0] key, input bit early_fin);
        int l;
        bit go;
        l = (key_mid && lat < 3) ? 3 : lat;
        go = m_play;
        sample_tick = 1; cyc(); sample_tick = 0;
        chk("tick_start", flash_start, go);
        if (!go) begin
            cyc();
            chk("idle_start", flash_start, 0);
            check_state("idle");
            return;
        end
        chk("req_addr", flash_addr, m_addr);
        // A finish during the request cycle must be ignored.
        if (early_fin) flash_finish = 1;
        cyc(); flash_finish = 0;
        for (int w = 0; w < l; w++) begin
            chk("wait_start", flash_start, 0);
            chk("wait_addr", flash_addr, m_addr);
            if (w == 0 && tick_mid) begin sample_tick = 1; m_ovr = 1; end
            if (w == 1 && key_mid) begin kbd_code = key; kbd_valid = 1; apply_key(key); end
            cyc();
            sample_tick = 0; kbd_valid = 0;
        end
        flash_finish = 1; cyc(); flash_finish = 0;
        ref_step();
        chk("step_wrap", wrap, e_wrap);
        check_state("step");
        cyc();
        chk("wrap_pulse", wrap, 0);
        chk("step_start", flash_start, 0);
        cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) cyc();
        chk("rst_start", flash_start, 0);
        chk("rst_wrap", wrap, 0);
        check_state("rst");
        rst_n = 1; cyc();

        // Three basic forward reads from START_ADDR.
        press(K_E);
        repeat (3) do_read(5, 0, 0, 8'h00, 0);

        // A key in the same cycle as a tick: the tick sees the old (paused) state.
        press(K_D);
        kbd_code = K_E; kbd_valid = 1; sample_tick = 1; cyc();
        kbd_valid = 0; sample_tick = 0;
        chk("old_play_start", flash_start, 0);
        repeat (3) cyc();
        apply_key(K_E);
        check_state("old_play");

        // Tick during WAIT sets overrun; a restart in WAIT clears it and lands on the window edge.
        do_read(4, 1, 0, 8'h00, 0);
        do_read(4, 1, 1, K_R, 0);
        do_read(2, 0, 0, 8'h00, 1);

        // Run past both window edges.
        press(K_F);
        repeat (12) do_read(2, 0, 0, 8'h00, 0);
        press(K_B);
        repeat (12) do_read(2, 0, 0, 8'h00, 0);

        for (int i = 0; i < 90; i++) begin
            if ($urandom_range(0, 9) < 3) press(pick_key());
            else do_read(int'($urandom_range(1, 6)), $urandom_range(0, 3) == 0,
                         $urandom_range(0, 3) == 0, pick_key(), $urandom_range(0, 4) == 0);
        end

        // Reset while a read is outstanding; the late finish must do nothing.
        press(K_F);
        if (!m_play) press(K_E);
        sample_tick = 1; cyc(); sample_tick = 0;
        cyc();
        rst_n = 0; cyc(); rst_n = 1;
        model_reset();
        flash_finish = 1; cyc(); flash_finish = 0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_wait_start", flash_start, 0);
            chk("rst_wait_wrap", wrap, 0);
            check_state("rst_wait");
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
